// File: rtl/ramunchain_if.sv
// Snapshot-in / word-stream-out handshake bundle for ramunchain.
// The master drives snapshots and downstream ready; the slave is the serialiser.
interface ramunchain_if #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 64
);
    logic [LENGTH-1:0][WIDTH-1:0] i_taps;
    logic                         i_valid;
    logic                         i_ready;
    logic [WIDTH-1:0]             o_dat;
    logic                         o_valid;
    logic                         o_ready;
    logic                         o_last;
    logic                         busy;

    modport master (
        output i_taps, i_valid, o_ready,
        input  i_ready, o_dat, o_valid, o_last, busy
    );

    modport slave (
        input  i_taps, i_valid, o_ready,
        output i_ready, o_dat, o_valid, o_last, busy
    );
endinterface

// File: rtl/ramunchain.sv
// Parallel-in / serial-out re-serialiser: captures LENGTH taps in one transfer
// and streams them one word per accepted beat, back-to-back without bubbles.
//
// state  | meaning
// IDLE   | nothing held, ready for a snapshot
// STREAM | snapshot held, presenting word idx on o_dat
module ramunchain #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 64,
    parameter int ORDER  = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    ramunchain_if.slave  bus
);
    localparam int            IW       = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(LENGTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                       state_q,  state_d;
    logic [IW-1:0]                idx_q,    idx_d;
    logic [WIDTH-1:0]             o_dat_q,  o_dat_d;
    logic                         o_last_q, o_last_d;
    logic [LENGTH-1:0][WIDTH-1:0] mem_q,    mem_d;

    logic          o_valid;
    logic          i_ready;
    logic          fire;
    logic          load;
    logic [IW-1:0] idx_nxt;

    function automatic logic [WIDTH-1:0] pick(
        input logic [LENGTH-1:0][WIDTH-1:0] arr,
        input logic [IW-1:0]                n
    );
        logic [IW-1:0] k;
        k = (ORDER != 0) ? n : (IDX_LAST - n);
        return arr[k];
    endfunction

    assign o_valid = (state_q == STREAM);
    assign fire    = o_valid & bus.o_ready;
    // A new snapshot may land on the same edge that retires the final word.
    assign i_ready = (state_q == IDLE) | (fire & o_last_q);
    assign load    = bus.i_valid & i_ready;
    assign idx_nxt = idx_q + 1'b1;

    assign bus.i_ready = i_ready;
    assign bus.o_valid = o_valid;
    assign bus.busy    = o_valid;
    assign bus.o_dat   = o_dat_q;
    assign bus.o_last  = o_last_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        o_dat_d  = o_dat_q;
        o_last_d = o_last_q;
        mem_d    = mem_q;
        if (load) begin
            mem_d    = bus.i_taps;
            state_d  = STREAM;
            idx_d    = '0;
            o_dat_d  = pick(bus.i_taps, '0);
            o_last_d = (LENGTH == 1);
        end else if (fire) begin
            if (o_last_q) begin
                state_d  = IDLE;
                o_last_d = 1'b0;
            end else begin
                idx_d    = idx_nxt;
                o_dat_d  = pick(mem_q, idx_nxt);
                o_last_d = (idx_nxt == IDX_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            o_dat_q  <= '0;
            o_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            o_dat_q  <= o_dat_d;
            o_last_q <= o_last_d;
        end
    end

    // Snapshot storage carries no reset; its contents only matter after a load.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
